// File: rtl/field_snapshot_mux.sv
// Frame-synchronised display-field selector: copies one priority-selected source into a
// registered field bank, one field per cycle, on each frame tick. Optional macro: FIELD_BCD_CHECK_EN.
module field_snapshot_mux #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_FIELDS  = 11,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DEFAULT_SRC = NUM_SRC - 1,
  parameter logic [NUM_SRC*NUM_FIELDS-1:0] ZERO_MASK = '0,
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SRC*NUM_FIELDS*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]                mode_req,
  input  logic                              frame_tick,
  input  logic                              freeze,
  input  logic                              clr_overrun,
  output logic [NUM_FIELDS*WIDTH-1:0]       field_data,
  output logic [SRC_W-1:0]                  active_src,
  output logic                              busy,
  output logic                              update_done,
  output logic                              overrun,
  output logic                              bcd_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [NUM_SRC-1:0][NUM_FIELDS-1:0] MASK_PK = ZERO_MASK;

`ifdef FIELD_BCD_CHECK_EN
  // Replacement pattern: every nibble 0xE.
  function automatic logic [WIDTH-1:0] bcd_bad_pattern();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < int'(WIDTH); i++) v[i] = ((i % 4) != 0);
    return v;
  endfunction

  function automatic logic is_bcd(input logic [WIDTH-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int n = 0; n < int'(WIDTH / 4); n++) begin
      if (v[n*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  localparam logic [WIDTH-1:0] BCD_BAD = bcd_bad_pattern();
`endif

  logic [NUM_SRC-1:0][NUM_FIELDS-1:0][WIDTH-1:0] src_pk;
  assign src_pk = src_data;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [SRC_W-1:0]                src_q, src_d;
  logic [NUM_FIELDS-1:0][WIDTH-1:0] field_q, field_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            overrun_q, overrun_d;
  logic                            bcd_err_q, bcd_err_d;
  logic [SRC_W-1:0]                sel_src;
  logic [WIDTH-1:0]                raw_val, field_val;
  logic                            masked, bad_field;

  // Priority pick: lowest set request wins, otherwise the default source.
  always_comb begin
    sel_src = SRC_W'(DEFAULT_SRC);
    for (int s = int'(NUM_SRC) - 1; s >= 0; s--) begin
      if (mode_req[s]) sel_src = SRC_W'(s);
    end
  end

  // Value written for the current field of the latched source.
  always_comb begin
    raw_val   = src_pk[src_q][idx_q];
    masked    = MASK_PK[src_q][idx_q];
    bad_field = 1'b0;
    field_val = masked ? '0 : raw_val;
`ifdef FIELD_BCD_CHECK_EN
    if (!masked && !is_bcd(raw_val)) begin
      field_val = BCD_BAD;
      bad_field = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    src_d     = src_q;
    field_d   = field_q;
    busy_d    = (state_q == COPY);
    done_d    = (state_q == DONE);
    overrun_d = overrun_q;
    bcd_err_d = bcd_err_q;

    if (clr_overrun) overrun_d = 1'b0;
    // A tick that cannot start a copy is an overrun; set beats clear.
    if (frame_tick && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_tick && !freeze) begin
          state_d = COPY;
          src_d   = sel_src;
          idx_d   = '0;
        end
      end
      COPY: begin
        field_d[idx_q] = field_val;
        if (bad_field) bcd_err_d = 1'b1;
        if (idx_q == IDX_W'(NUM_FIELDS - 1)) state_d = DONE;
        else                                 idx_d   = idx_q + IDX_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q     <= '0;
      src_q     <= SRC_W'(DEFAULT_SRC);
      field_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      src_q     <= src_d;
      field_q   <= field_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  assign field_data  = field_q;
  assign active_src  = src_q;
  assign busy        = busy_q;
  assign update_done = done_q;
  assign overrun     = overrun_q;
  assign bcd_err     = bcd_err_q;

endmodule

// File: tb/tb_field_snapshot_mux.sv
// Directed bench for field_snapshot_mux; honours FIELD_BCD_CHECK_EN when defined.
module tb_field_snapshot_mux;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NF    = 11;
  localparam int unsigned NS    = 4;
  localparam logic [NS*NF-1:0] ZMASK = 44'h700;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NS*NF*WIDTH-1:0]    src_data = '0;
  logic [NS-1:0]             mode_req = '0;
  logic                      frame_tick = 1'b0;
  logic                      freeze = 1'b0;
  logic                      clr_overrun = 1'b0;
  logic [NF*WIDTH-1:0]       field_data;
  logic [1:0]                active_src;
  logic                      busy, update_done, overrun, bcd_err;

  int checks = 0;
  int failures = 0;

  field_snapshot_mux #(
    .WIDTH(WIDTH), .NUM_FIELDS(NF), .NUM_SRC(NS), .DEFAULT_SRC(NS - 1), .ZERO_MASK(ZMASK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .mode_req(mode_req),
    .frame_tick(frame_tick), .freeze(freeze), .clr_overrun(clr_overrun),
    .field_data(field_data), .active_src(active_src), .busy(busy),
    .update_done(update_done), .overrun(overrun), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  // Expected display value of a copied, unmasked field.
  function automatic logic [7:0] fix(input logic [7:0] v);
`ifdef FIELD_BCD_CHECK_EN
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9) return 8'hEE;
`endif
    return v;
  endfunction

  function automatic logic [7:0] src_val(input int s, input int f);
    return src_data[(s*NF+f)*WIDTH +: WIDTH];
  endfunction

  function automatic logic [7:0] fld(input int f);
    return field_data[f*WIDTH +: WIDTH];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves the bench 1 time unit after edge T, the edge that sampled the tick.
  task automatic start_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic init_sources();
    for (int f = 0; f < int'(NF); f++) begin
      src_data[(0*NF+f)*WIDTH +: WIDTH] = (f < 8) ? 8'(8'h40 + f) : 8'h59;
      src_data[(1*NF+f)*WIDTH +: WIDTH] = (f < 10) ? 8'(8'h10 + f) : 8'h20;
      src_data[(2*NF+f)*WIDTH +: WIDTH] = (f < 10) ? 8'(8'h70 + f) : 8'h80;
      src_data[(3*NF+f)*WIDTH +: WIDTH] = 8'(f);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    steps(2);
    checks++;
    if (field_data !== '0) begin failures++; $display("FAIL reset_fields got=%h exp=0", field_data); end
    checks++;
    if (active_src !== 2'd3) begin failures++; $display("FAIL reset_active_src got=%0d exp=3", active_src); end
    checks++;
    if ({busy, update_done, overrun, bcd_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, update_done, overrun, bcd_err});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int pulses;
    int pulse_at;
    pulses = 0;
    pulse_at = -1;
    mode_req = 4'b0000;
    start_tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_T got=%b exp=0", busy); end
    for (int k = 0; k < int'(NF); k++) begin
      step();
      checks++;
      if (fld(k) !== fix(8'(k)) || busy !== 1'b1) begin
        failures++; $display("FAIL basic_field%0d got=%h busy=%b exp=%h busy=1", k, fld(k), busy, fix(8'(k)));
      end
      if (update_done) begin pulses++; pulse_at = k + 1; end
    end
    for (int c = 12; c <= 14; c++) begin
      step();
      if (c == 12) begin
        checks++;
        if (busy !== 1'b0 || active_src !== 2'd3) begin
          failures++; $display("FAIL basic_end got busy=%b src=%0d exp busy=0 src=3", busy, active_src);
        end
      end
      if (update_done) begin pulses++; pulse_at = c; end
    end
    checks++;
    if (pulses != 1 || pulse_at != 12) begin
      failures++; $display("FAIL basic_done_pulse got count=%0d at=%0d exp count=1 at=12", pulses, pulse_at);
    end
  endtask

  task automatic test_priority();
    mode_req = 4'b0110;
    start_tick();
    checks++;
    if (active_src !== 2'd1) begin failures++; $display("FAIL prio_src got=%0d exp=1", active_src); end
    steps(3);
    mode_req = 4'b0001;
    steps(9);
    checks++;
    if (update_done !== 1'b1 || active_src !== 2'd1) begin
      failures++; $display("FAIL prio_end got done=%b src=%0d exp done=1 src=1", update_done, active_src);
    end
    for (int f = 0; f < int'(NF); f++) begin
      checks++;
      if (fld(f) !== fix(src_val(1, f))) begin
        failures++; $display("FAIL prio_field%0d got=%h exp=%h", f, fld(f), fix(src_val(1, f)));
      end
    end
    step();
  endtask

  task automatic test_zero_mask();
    mode_req = 4'b0001;
    start_tick();
    steps(13);
    checks++;
    if (active_src !== 2'd0) begin failures++; $display("FAIL zmask_src got=%0d exp=0", active_src); end
    for (int f = 0; f < int'(NF); f++) begin
      logic [7:0] exp_v;
      exp_v = (f >= 8) ? 8'h00 : fix(src_val(0, f));
      checks++;
      if (fld(f) !== exp_v) begin failures++; $display("FAIL zmask_field%0d got=%h exp=%h", f, fld(f), exp_v); end
    end
  endtask

  task automatic test_overrun();
    mode_req = 4'b0000;
    start_tick();
    steps(4);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL ovr_set got ovr=%b busy=%b exp ovr=1 busy=1", overrun, busy);
    end
    frame_tick = 1'b1;
    clr_overrun = 1'b1;
    step();
    frame_tick = 1'b0;
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
    steps(6);
    checks++;
    if (busy !== 1'b0 || update_done !== 1'b1) begin
      failures++; $display("FAIL ovr_copy_end got busy=%b done=%b exp busy=0 done=1", busy, update_done);
    end
    for (int f = 0; f < int'(NF); f++) begin
      checks++;
      if (fld(f) !== fix(src_val(3, f))) begin
        failures++; $display("FAIL ovr_field%0d got=%h exp=%h", f, fld(f), fix(src_val(3, f)));
      end
    end
    step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    freeze = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    steps(2);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || update_done !== 1'b0) begin
      failures++; $display("FAIL freeze got busy=%b ovr=%b done=%b exp 0 0 0", busy, overrun, update_done);
    end
    freeze = 1'b0;
  endtask

  task automatic test_reset_midcopy();
    mode_req = 4'b0010;
    start_tick();
    steps(6);
    reset_n = 1'b0;
    step();
    checks++;
    if (field_data !== '0 || busy !== 1'b0 || active_src !== 2'd3 || update_done !== 1'b0) begin
      failures++;
      $display("FAIL midreset got fields=%h busy=%b src=%0d done=%b exp 0 0 3 0",
               field_data, busy, active_src, update_done);
    end
    reset_n = 1'b1;
    mode_req = 4'b0000;
    step();
    start_tick();
    steps(12);
    checks++;
    if (update_done !== 1'b1) begin failures++; $display("FAIL midreset_recopy_done got=%b exp=1", update_done); end
    for (int f = 0; f < int'(NF); f++) begin
      checks++;
      if (fld(f) !== fix(src_val(3, f))) begin
        failures++; $display("FAIL midreset_field%0d got=%h exp=%h", f, fld(f), fix(src_val(3, f)));
      end
    end
    step();
  endtask

  task automatic test_bcd();
    logic [7:0] exp_f2;
    logic       exp_err;
`ifdef FIELD_BCD_CHECK_EN
    exp_f2  = 8'hEE;
    exp_err = 1'b1;
`else
    exp_f2  = 8'h3A;
    exp_err = 1'b0;
`endif
    src_data[(3*NF+2)*WIDTH +: WIDTH] = 8'h3A;
    mode_req = 4'b0000;
    start_tick();
    steps(12);
    checks++;
    if (fld(2) !== exp_f2) begin failures++; $display("FAIL bcd_field2 got=%h exp=%h", fld(2), exp_f2); end
    checks++;
    if (bcd_err !== exp_err) begin failures++; $display("FAIL bcd_err got=%b exp=%b", bcd_err, exp_err); end
    checks++;
    if (fld(1) !== 8'h01) begin failures++; $display("FAIL bcd_field1 got=%h exp=01", fld(1)); end
    step();
  endtask

  initial begin
    init_sources();
    test_reset();
    test_basic();
    test_priority();
    test_zero_mask();
    test_overrun();
    test_reset_midcopy();
    test_bcd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
